// File: rtl/vblank_update_scheduler.sv
// Schedules multi-phase game-state updates inside vertical blanking, one sequence
// every FRAMES_PER_TICK frames, with a sticky overrun flag if a sequence misses its frame.
module vblank_update_scheduler #(
    parameter int unsigned TOTAL_COLS      = 800,
    parameter int unsigned TOTAL_ROWS      = 525,
    parameter int unsigned ACTIVE_ROWS     = 480,
    parameter int unsigned NUM_PHASES      = 3,
    parameter int unsigned FRAMES_PER_TICK = 4
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [9:0] i_Row_Count,
    input  logic [9:0] i_Col_Count,
    input  logic       i_Run,
    input  logic       i_Phase_Done,
    output logic       o_Phase_Start,
    output logic [1:0] o_Phase_Id,
    output logic       o_Busy,
    output logic       o_Frame_Strobe,
    output logic [7:0] o_Update_Count,
    output logic       o_Overrun
);

    localparam int unsigned DivW = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
    localparam logic [DivW-1:0] DivLast   = DivW'(FRAMES_PER_TICK - 1);
    localparam logic [1:0]      PhaseLast = 2'(NUM_PHASES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [7:0]      count_q, count_d;
    logic            overrun_q, overrun_d;
    logic            strobe_q;
    logic [DivW-1:0] div_q;

    logic vb;
    logic wrap;
    logic tick;

    assign vb   = (i_Row_Count == 10'(ACTIVE_ROWS)) && (i_Col_Count == 10'd0);
    assign wrap = (i_Row_Count == 10'(TOTAL_ROWS - 1)) && (i_Col_Count == 10'(TOTAL_COLS - 1));
    assign tick = vb && (div_q == DivLast);

    // Frame divider and blanking strobe run independently of i_Run.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            div_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= vb;
            if (vb) begin
                div_q <= (div_q == DivLast) ? '0 : div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= StIdle;
            phase_q   <= 2'd0;
            count_q   <= 8'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        unique case (state_q)
            StIdle: begin
                if (tick && i_Run) begin
                    state_d = StStart;
                    phase_d = 2'd0;
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (i_Phase_Done) begin
                    if (phase_q < PhaseLast) begin
                        phase_d = phase_q + 2'd1;
                        state_d = StStart;
                    end else begin
                        phase_d = 2'd0;
                        state_d = StIdle;
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                phase_d = 2'd0;
            end
        endcase

        // Deadline check sees the result of this cycle's done, so a last-phase
        // done landing exactly on the wrap still completes cleanly.
        if (wrap && (state_d != StIdle)) begin
            overrun_d = 1'b1;
            state_d   = StIdle;
            phase_d   = 2'd0;
        end
    end

    assign o_Phase_Start  = (state_q == StStart) && !i_Reset;
    assign o_Busy         = (state_q != StIdle);
    assign o_Phase_Id     = phase_q;
    assign o_Frame_Strobe = strobe_q;
    assign o_Update_Count = count_q;
    assign o_Overrun      = overrun_q;

endmodule
